// File: rtl/ysyx_24120013_cycle_ctrl_if.sv
// Memory handshake bundle between the cycle controller (master) and the
// instruction/data memories (slave).
interface ysyx_24120013_cycle_ctrl_if;
  logic imem_req_valid;
  logic imem_req_ready;
  logic imem_rsp_valid;
  logic imem_rsp_ready;
  logic dmem_req_valid;
  logic dmem_req_ready;
  logic dmem_rsp_valid;

  modport master (
    output imem_req_valid, imem_rsp_ready, dmem_req_valid,
    input  imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid
  );

  modport slave (
    input  imem_req_valid, imem_rsp_ready, dmem_req_valid,
    output imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid
  );
endinterface

// File: rtl/ysyx_24120013_cycle_ctrl.sv
// Per-instruction multi-cycle sequencer for the core datapath.
// Optional memory-handshake timeout: define YSYX_24120013_CTRL_TIMEOUT_EN.
module ysyx_24120013_cycle_ctrl #(
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_24120013_cycle_ctrl_if.master mem,
  output logic                     inst_latch_en,
  input  logic                     dec_is_mem,
  input  logic                     dec_is_halt,
  input  logic                     dec_illegal,
  output logic                     rf_wen_gate,
  output logic                     pc_update,
  output logic                     halted,
  output logic                     illegal,
  output logic                     timeout_err,
  output logic [CNT_WIDTH-1:0]     retire_cnt,
  output logic [3:0]               state_o
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FETCH_REQ  = 4'd1,
    FETCH_WAIT = 4'd2,
    DECODE     = 4'd3,
    EXEC       = 4'd4,
    MEM_REQ    = 4'd5,
    MEM_WAIT   = 4'd6,
    WB         = 4'd7,
    HALT       = 4'd8
  } state_e;

  if (TIMEOUT_CYCLES < 1 || longint'(TIMEOUT_CYCLES) >= (64'd1 << TO_WIDTH)) begin : g_bad_timeout_cfg
    $error("TO_WIDTH cannot hold TIMEOUT_CYCLES");
  end

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] retire_q;
  logic                 halted_q, illegal_q;
  logic                 imem_req_valid_q, imem_rsp_ready_q, dmem_req_valid_q, wb_q;
  logic                 ret_inc, set_halt, set_ill;

`ifdef YSYX_24120013_CTRL_TIMEOUT_EN
  logic [TO_WIDTH-1:0]  to_q;
  logic                 timeout_err_q;
  logic                 set_to;
  logic                 waiting;
`endif

  always_comb begin
    state_d  = state_q;
    ret_inc  = 1'b0;
    set_halt = 1'b0;
    set_ill  = 1'b0;
    unique case (state_q)
      IDLE:       state_d = FETCH_REQ;
      FETCH_REQ:  if (mem.imem_req_ready) state_d = FETCH_WAIT;
      FETCH_WAIT: if (mem.imem_rsp_valid) state_d = DECODE;
      DECODE: begin
        // Illegal wins over ebreak and does not count as a retirement.
        if (dec_illegal) begin
          state_d  = HALT;
          set_halt = 1'b1;
          set_ill  = 1'b1;
        end else if (dec_is_halt) begin
          state_d  = HALT;
          set_halt = 1'b1;
          ret_inc  = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC:       state_d = dec_is_mem ? MEM_REQ : WB;
      MEM_REQ:    if (mem.dmem_req_ready) state_d = MEM_WAIT;
      MEM_WAIT:   if (mem.dmem_rsp_valid) state_d = WB;
      WB: begin
        ret_inc = 1'b1;
        state_d = FETCH_REQ;
      end
      HALT:       state_d = HALT;
      default:    state_d = IDLE;
    endcase
`ifdef YSYX_24120013_CTRL_TIMEOUT_EN
    // A handshake on the limit cycle has already moved state_d away, so it wins.
    waiting = (state_q == FETCH_REQ) || (state_q == FETCH_WAIT) ||
              (state_q == MEM_REQ)   || (state_q == MEM_WAIT);
    set_to  = 1'b0;
    if (waiting && (state_d == state_q) && (to_q == TO_WIDTH'(TIMEOUT_CYCLES - 1))) begin
      state_d  = HALT;
      set_halt = 1'b1;
      set_to   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      retire_q         <= '0;
      halted_q         <= 1'b0;
      illegal_q        <= 1'b0;
      imem_req_valid_q <= 1'b0;
      imem_rsp_ready_q <= 1'b0;
      dmem_req_valid_q <= 1'b0;
      wb_q             <= 1'b0;
`ifdef YSYX_24120013_CTRL_TIMEOUT_EN
      to_q             <= '0;
      timeout_err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (ret_inc)  retire_q  <= retire_q + 1'b1;
      if (set_halt) halted_q  <= 1'b1;
      if (set_ill)  illegal_q <= 1'b1;
      // Strobes are registered from the next state so they follow state_q exactly.
      imem_req_valid_q <= (state_d == FETCH_REQ);
      imem_rsp_ready_q <= (state_d == FETCH_WAIT);
      dmem_req_valid_q <= (state_d == MEM_REQ);
      wb_q             <= (state_d == WB);
`ifdef YSYX_24120013_CTRL_TIMEOUT_EN
      if (set_to) timeout_err_q <= 1'b1;
      if (state_d != state_q) to_q <= '0;
      else if (waiting)       to_q <= to_q + 1'b1;
`endif
    end
  end

  assign mem.imem_req_valid = imem_req_valid_q;
  assign mem.imem_rsp_ready = imem_rsp_ready_q;
  assign mem.dmem_req_valid = dmem_req_valid_q;
  assign inst_latch_en      = (state_q == FETCH_WAIT) && mem.imem_rsp_valid;
  assign rf_wen_gate        = wb_q;
  assign pc_update          = wb_q;
  assign halted             = halted_q;
  assign illegal            = illegal_q;
  assign retire_cnt         = retire_q;
  assign state_o            = state_q;

`ifdef YSYX_24120013_CTRL_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24120013_cycle_ctrl.sv
// Randomized bench: builds the expected per-cycle trace of each instruction
// from latency rules and checks the controller against it every cycle.
module tb_ysyx_24120013_cycle_ctrl;
  localparam int TO_LIM = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_latch_en, rf_wen_gate, pc_update, halted, illegal, timeout_err;
  logic        dec_is_mem = 1'b0, dec_is_halt = 1'b0, dec_illegal = 1'b0;
  logic [31:0] retire_cnt;
  logic [3:0]  state_o;

  ysyx_24120013_cycle_ctrl_if mif();

  ysyx_24120013_cycle_ctrl #(.CNT_WIDTH(32), .TIMEOUT_CYCLES(TO_LIM), .TO_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .mem(mif),
    .inst_latch_en(inst_latch_en),
    .dec_is_mem(dec_is_mem), .dec_is_halt(dec_is_halt), .dec_illegal(dec_illegal),
    .rf_wen_gate(rf_wen_gate), .pc_update(pc_update),
    .halted(halted), .illegal(illegal), .timeout_err(timeout_err),
    .retire_cnt(retire_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // One entry per expected clock cycle: which phase the instruction is in,
  // whether the awaited handshake is offered this cycle, and decode inputs.
  typedef struct {
    int st;
    bit hs;
    bit dil;
    bit dha;
    bit dm;
    int ret;
    int cause;
  } ent_t;

  ent_t sched[$];
  int   r_model;
  int   n_chk = 0, n_err = 0;
  int   pcq[$];
  int   nlatch;
  bit   drv_rsp;

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d: got %0h want %0h", nm, k, act, exp);
    end
  endtask

  function automatic void push(input int st, input bit hs, input bit dil, input bit dha,
                               input bit dm, input int cause);
    ent_t e;
    e.st = st; e.hs = hs; e.dil = dil; e.dha = dha; e.dm = dm;
    e.ret = r_model; e.cause = cause;
    sched.push_back(e);
  endfunction

  function automatic void add_wait(input int st, input int w);
    for (int i = 0; i < w; i++) push(st, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    push(st, 1'b1, 1'b0, 1'b0, 1'b0, 0);
  endfunction

  function automatic void start_sched();
    sched.delete();
    r_model = 0;
    push(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endfunction

  function automatic void add_op(input bit is_mem, input int w1, input int w2,
                                 input int w3, input int w4);
    add_wait(1, w1);
    add_wait(2, w2);
    push(3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    push(4, 1'b0, 1'b0, 1'b0, is_mem, 0);
    if (is_mem) begin
      add_wait(5, w3);
      add_wait(6, w4);
    end
    push(7, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    r_model++;
  endfunction

  // kind 0: ebreak (retires); kind 1: illegal, with random ebreak alongside.
  function automatic void add_stop(input int kind, input int w1, input int w2);
    add_wait(1, w1);
    add_wait(2, w2);
    if (kind == 0) begin
      push(3, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      r_model++;
    end else begin
      push(3, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 0);
    end
    for (int i = 0; i < 20; i++) push(8, 1'b0, 1'b0, 1'b0, 1'b0, kind);
  endfunction

  task automatic drive(input ent_t e);
    mif.imem_req_ready = (e.st == 1) ? e.hs : 1'($urandom_range(0, 1));
    mif.imem_rsp_valid = (e.st == 2) ? e.hs : 1'($urandom_range(0, 1));
    mif.dmem_req_ready = (e.st == 5) ? e.hs : 1'($urandom_range(0, 1));
    mif.dmem_rsp_valid = (e.st == 6) ? e.hs : 1'($urandom_range(0, 1));
    dec_illegal        = (e.st == 3) ? e.dil : 1'($urandom_range(0, 1));
    dec_is_halt        = (e.st == 3) ? e.dha : 1'($urandom_range(0, 1));
    dec_is_mem         = (e.st == 4) ? e.dm  : 1'($urandom_range(0, 1));
    drv_rsp            = mif.imem_rsp_valid;
  endtask

  task automatic compare(input int k, input ent_t e);
    logic [8:0] exp_s, act_s;
    exp_s = {e.st == 1, e.st == 2, (e.st == 2) && drv_rsp, e.st == 5,
             e.st == 7, e.st == 7, e.st == 8,
             (e.st == 8) && (e.cause == 1), (e.st == 8) && (e.cause == 2)};
    act_s = {mif.imem_req_valid, mif.imem_rsp_ready, inst_latch_en, mif.dmem_req_valid,
             rf_wen_gate, pc_update, halted, illegal, timeout_err};
    chk("strobes", k, longint'(act_s), longint'(exp_s));
    chk("state", k, longint'(state_o), longint'(e.st));
    chk("retire", k, longint'(retire_cnt), longint'(e.ret));
    if (pc_update === 1'b1) pcq.push_back(k);
    if (inst_latch_en === 1'b1) nlatch++;
  endtask

  // Reset, release on a falling edge, then walk the expected trace; optionally
  // pulse reset asynchronously in the middle of cycle abort_at.
  task automatic run(input int abort_at);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pcq.delete();
    nlatch = 0;
    for (int k = 0; k < sched.size(); k++) begin
      drive(sched[k]);
      #1;
      compare(k, sched[k]);
      if (k == abort_at) begin
        #1 rst = 1'b1;
        #1;
        chk("abort state", k, longint'(state_o), 0);
        chk("abort retire", k, longint'(retire_cnt), 0);
        chk("abort strobes", k, longint'({pc_update, rf_wen_gate, mif.dmem_req_valid,
                                          mif.imem_req_valid}), 0);
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    mif.imem_req_ready = 1'b0;
    mif.imem_rsp_valid = 1'b0;
    mif.dmem_req_ready = 1'b0;
    mif.dmem_rsp_valid = 1'b0;

    // Three zero-wait ALU ops, then illegal+ebreak together.
    start_sched();
    for (int i = 0; i < 3; i++) add_op(1'b0, 0, 0, 0, 0);
    add_stop(1, 0, 0);
    sched[sched.size() - 21].dha = 1'b1;
    run(-1);
    chk("r0 pc count", 0, longint'(pcq.size()), 3);
    chk("r0 pc first", 0, longint'(pcq.size() > 0 ? pcq[0] : -1), 5);
    chk("r0 pc second", 0, longint'(pcq.size() > 1 ? pcq[1] : -1), 10);
    chk("r0 pc third", 0, longint'(pcq.size() > 2 ? pcq[2] : -1), 15);
    chk("r0 retire", 0, longint'(retire_cnt), 3);
    chk("r0 illegal", 0, longint'({halted, illegal}), 3);

    // Instruction memory stalls the request four cycles.
    start_sched();
    add_op(1'b0, 4, 0, 0, 0);
    add_stop(0, 0, 0);
    run(-1);
    chk("r1 pc count", 1, longint'(pcq.size()), 1);
    chk("r1 pc at", 1, longint'(pcq.size() > 0 ? pcq[0] : -1), 9);
    chk("r1 latches", 1, longint'(nlatch), 2);
    chk("r1 retire", 1, longint'(retire_cnt), 2);

    // Load whose data response arrives two cycles late.
    start_sched();
    add_op(1'b1, 0, 0, 0, 2);
    add_stop(0, 0, 0);
    run(-1);
    chk("r2 wb count", 2, longint'(pcq.size()), 1);
    chk("r2 wb at", 2, longint'(pcq.size() > 0 ? pcq[0] : -1), 9);
    chk("r2 halted", 2, longint'({halted, illegal}), 2);

    // Reset while a load waits for its data response.
    start_sched();
    add_op(1'b0, 0, 0, 0, 0);
    add_op(1'b1, 0, 0, 0, 5);
    run(12);

    for (int n = 0; n < 40; n++) begin
      int nops;
      start_sched();
      nops = $urandom_range(1, 6);
      for (int i = 0; i < nops; i++)
        add_op(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 5),
               $urandom_range(0, 5), $urandom_range(0, 5));
      add_stop($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3));
      run((n % 7 == 3) ? $urandom_range(1, 15) : -1);
    end

`ifdef YSYX_24120013_CTRL_TIMEOUT_EN
    // Instruction word never arrives: give up after TO_LIM wait cycles.
    start_sched();
    add_wait(1, 1);
    for (int i = 0; i < TO_LIM; i++) push(2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 20; i++) push(8, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    run(-1);
    chk("to flag", 90, longint'({halted, timeout_err, illegal}), 6);

    // Response lands on the limit cycle: normal progress.
    start_sched();
    add_op(1'b0, 0, TO_LIM - 1, 0, 0);
    add_op(1'b1, TO_LIM - 1, 0, TO_LIM - 1, TO_LIM - 1);
    add_stop(0, 0, 0);
    run(-1);
    chk("to edge retire", 91, longint'(retire_cnt), 3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24120013_cycle_ctrl.md
Name: ysyx_24120013_cycle_ctrl

Overview:
- Multi-cycle sequencer for the core datapath (PC, IFU, IDU, register file, EXU).
- Replaces free-running single-cycle stepping with a per-instruction state machine.
- Handshakes with instruction and data memory, and gates the PC update and register-file write to one cycle per instruction.
- Provides halt/illegal status and a retired-instruction counter for the simulation environment.

Parameters:
- CNT_WIDTH, 32, width of retire_cnt
- TIMEOUT_CYCLES, 255, maximum wait cycles per memory handshake (used only with the optional feature)
- TO_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- imem_req_valid  output  1  fetch request to instruction memory
- imem_req_ready  input  1  instruction memory accepts request
- imem_rsp_valid  input  1  instruction word valid
- imem_rsp_ready  output  1  controller accepts instruction word
- inst_latch_en  output  1  IFU captures the instruction this cycle
- dec_is_mem  input  1  decoded instruction is a load/store
- dec_is_halt  input  1  decoded instruction is ebreak
- dec_illegal  input  1  decoded instruction is illegal
- dmem_req_valid  output  1  data memory request
- dmem_req_ready  input  1  data memory accepts request
- dmem_rsp_valid  input  1  data memory response/ack
- rf_wen_gate  output  1  ANDed with EXU_wen at the register file
- pc_update  output  1  PC loads next/jump value this cycle
- halted  output  1  core stopped (sticky)
- illegal  output  1  stop caused by an illegal instruction (sticky)
- timeout_err  output  1  stop caused by a memory timeout (sticky)
- retire_cnt  output  CNT_WIDTH  retired-instruction count
- state_o  output  4  current state encoding (debug)

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE (0); retire_cnt = 0.
  - halted, illegal and timeout_err = 0.
  - All strobe outputs = 0.
- State encodings: IDLE=0, FETCH_REQ=1, FETCH_WAIT=2, DECODE=3, EXEC=4, MEM_REQ=5, MEM_WAIT=6, WB=7, HALT=8.
- All strobes are Moore outputs decoded from the registered state, except inst_latch_en.
- IDLE -> FETCH_REQ unconditionally on the first clock after reset release.
- FETCH_REQ:
  - imem_req_valid = 1.
  - On imem_req_ready: -> FETCH_WAIT. Otherwise stay; valid stays high.
- FETCH_WAIT:
  - imem_rsp_ready = 1.
  - inst_latch_en = imem_rsp_valid (combinational).
  - On imem_rsp_valid: -> DECODE.
- DECODE (decode inputs sampled here, in priority order):
  - dec_illegal: -> HALT; set halted and illegal.
  - else dec_is_halt: -> HALT; set halted; retire_cnt += 1.
  - else: -> EXEC.
- EXEC: -> MEM_REQ if dec_is_mem, else -> WB.
- MEM_REQ:
  - dmem_req_valid = 1.
  - On dmem_req_ready: -> MEM_WAIT.
- MEM_WAIT: on dmem_rsp_valid -> WB.
- WB:
  - rf_wen_gate = 1 and pc_update = 1, for exactly one cycle.
  - retire_cnt += 1.
  - -> FETCH_REQ.
- HALT:
  - Absorbing state; all strobes 0; only reset leaves it.
  - halted, illegal and timeout_err are sticky in HALT.
- Latency with zero-wait memory:
  - Non-memory instruction: 5 cycles (FETCH_REQ through WB).
  - Load/store: 7 cycles.
  - Each wait cycle adds 1.
- retire_cnt wraps modulo 2^CNT_WIDTH with no flag.
- Responses arriving outside a WAIT state are ignored. A memory must not issue them.
- Reset asserted mid-instruction: immediate return to IDLE with no PC update and no register write. An outstanding memory transaction is abandoned.

Optional Feature:
- Macro: YSYX_24120013_CTRL_TIMEOUT_EN.
- When defined:
  - A TO_WIDTH counter clears on entry to FETCH_REQ, FETCH_WAIT, MEM_REQ and MEM_WAIT, and increments each cycle spent waiting in them.
  - When it reaches TIMEOUT_CYCLES without the awaited handshake: -> HALT; set halted and timeout_err; no retire.
  - A handshake in the same cycle the limit is reached wins (normal transition).
- When undefined: no counter; waits are unbounded; timeout_err is tied to 0.

Test Plan:
- Zero-wait memory, 3 non-memory instructions after reset release:
  - pc_update/rf_wen_gate pulse at cycles 6, 11 and 16 after release.
  - retire_cnt = 3.
- imem_req_ready held low 4 cycles:
  - imem_req_valid stays high throughout.
  - WB is delayed by exactly 4 cycles.
  - No duplicate inst_latch_en.
- Load with dmem_rsp_valid 2 cycles late:
  - WB occurs 9 cycles after FETCH_REQ entry.
  - Exactly one rf_wen_gate pulse.
- dec_illegal = 1 and dec_is_halt = 1 together in DECODE:
  - HALT; illegal = 1; halted = 1; retire_cnt unchanged.
  - All strobes remain 0 for 20 cycles.
- rst pulsed while in MEM_WAIT:
  - state_o = 0 immediately (asynchronous); retire_cnt = 0.
  - Fetch restarts one cycle after release.
- With YSYX_24120013_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES = 8, imem_rsp_valid never asserted:
  - HALT entered after 8 wait cycles; timeout_err = 1.
  - A repeat run with rsp on cycle 8 proceeds normally.
